// File: rtl/mux_sweep_ctrl_pkg.sv
// Shared types, constants and golden select-mux function for the mux sweep sequencer.
package mux_sweep_ctrl_pkg;

    localparam int unsigned DATA_W    = 3;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned NUM_STEPS = 8;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned RES_W     = 8;

    localparam logic [SEL_W-1:0] SEL_D0   = 2'd0;
    localparam logic [SEL_W-1:0] SEL_D2   = 2'd1;
    localparam logic [SEL_W-1:0] SEL_D1   = 2'd2;
    localparam logic [SEL_W-1:0] SEL_ZERO = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    // One select/data setting presented to the mux under test
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } mux_drive_t;

    function automatic logic golden(input logic [SEL_W-1:0] c, input logic [DATA_W-1:0] d);
        case (c)
            SEL_D0:  return d[0];
            SEL_D2:  return d[2];
            SEL_D1:  return d[1];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mux_sweep_ctrl_golden_ref.sv
// Combinational reference model of the 3:1 select mux.
module mux_golden_ref
    import mux_sweep_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              golden_c
);

    assign golden_c = golden(sel_i, data_i);

endmodule

// File: rtl/mux_sweep_ctrl.sv
// Sweeps all select codes over a latched pattern and its inverse, packs the
// mux responses into result and flags any disagreement with the golden model.
module mux_sweep_ctrl
    import mux_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mux_out,
    output logic [DATA_W-1:0] mux_data,
    output logic [SEL_W-1:0]  mux_sel,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    mux_drive_t          drv_q, drv_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [STEP_W-1:0]   k_nxt_c;
    logic                golden_c;

    assign k_nxt_c = k_q + STEP_W'(1);

    // Reference value for the setting currently driven onto the mux
    mux_golden_ref u_golden (
        .sel_i    (drv_q.sel),
        .data_i   (drv_q.data),
        .golden_c (golden_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            pat_q    <= '0;
            drv_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            drv_q    <= drv_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        drv_d    = drv_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;

        // With ena low every register simply holds, including a pending done pulse
        if (ena) begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        pat_d    = data_in;
                        result_d = '0;
                        err_d    = 1'b0;
                        k_d      = '0;
                        drv_d    = '{sel: SEL_D0, data: data_in};
                        cnt_d    = CNT_LOAD;
                        busy_d   = 1'b1;
                        state_d  = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    result_d[k_q] = mux_out;
                    if (mux_out != golden_c) begin
                        err_d = 1'b1;
                    end
                    if (k_q == LAST_STEP) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d        = k_nxt_c;
                        drv_d.sel  = k_nxt_c[SEL_W-1:0];
                        drv_d.data = k_nxt_c[STEP_W-1] ? ~pat_q : pat_q;
                        cnt_d      = CNT_LOAD;
                        state_d    = DRIVE;
                    end
                end
                DONE: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mux_data = drv_q.data;
    assign mux_sel  = drv_q.sel;
    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
